// File: rtl/leaf_stream_bridge_if.sv
//------------------------------------------------------------------------------
// leaf_stream_bridge_if
// Stream bundle between leaf_interface, leaf_stream_bridge and the HLS kernel.
// Channel i of any flat data vector occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
//
// Signals:
//   din_if2bridge / vld_if2bridge / ack_bridge2if      interface -> bridge
//   dout_bridge2kern / vld_bridge2kern / ack_kern2bridge bridge -> kernel Input_i
//   din_kern2bridge / vld_kern2bridge / ack_bridge2kern kernel Output_i -> bridge
//   dout_bridge2if / vld_bridge2if / ack_if2bridge      bridge -> interface
//
// Modports:
//   slave  : the bridge itself
//   master : the surroundings (leaf_interface on one side, kernel on the other)
//------------------------------------------------------------------------------
`timescale 1ns/1ps
interface leaf_stream_bridge_if #(
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_IN_PORTS  = 2,
    parameter int NUM_OUT_PORTS = 2
);
    logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  din_if2bridge;
    logic [NUM_IN_PORTS-1:0]               vld_if2bridge;
    logic [NUM_IN_PORTS-1:0]               ack_bridge2if;
    logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  dout_bridge2kern;
    logic [NUM_IN_PORTS-1:0]               vld_bridge2kern;
    logic [NUM_IN_PORTS-1:0]               ack_kern2bridge;

    logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_kern2bridge;
    logic [NUM_OUT_PORTS-1:0]              vld_kern2bridge;
    logic [NUM_OUT_PORTS-1:0]              ack_bridge2kern;
    logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] dout_bridge2if;
    logic [NUM_OUT_PORTS-1:0]              vld_bridge2if;
    logic [NUM_OUT_PORTS-1:0]              ack_if2bridge;

    modport slave (
        input  din_if2bridge, vld_if2bridge,
        output ack_bridge2if,
        output dout_bridge2kern, vld_bridge2kern,
        input  ack_kern2bridge,
        input  din_kern2bridge, vld_kern2bridge,
        output ack_bridge2kern,
        output dout_bridge2if, vld_bridge2if,
        input  ack_if2bridge
    );

    modport master (
        output din_if2bridge, vld_if2bridge,
        input  ack_bridge2if,
        input  dout_bridge2kern, vld_bridge2kern,
        output ack_kern2bridge,
        output din_kern2bridge, vld_kern2bridge,
        input  ack_bridge2kern,
        input  dout_bridge2if, vld_bridge2if,
        output ack_if2bridge
    );
endinterface

// File: rtl/leaf_stream_bridge.sv
//------------------------------------------------------------------------------
// leaf_stream_bridge
// User-side bridge between the leaf_interface vld/ack streams and an HLS
// kernel with ap_hs streams and ap_ctrl_hs control. Every channel, in either
// direction, passes through its own first-word-fall-through FIFO of depth
// 2**FIFO_DEPTH_BITS. A small controller issues ap_start a configurable number
// of times (cfg_runs, 0 = forever) and then halts; FIFOs keep streaming.
//
// Ports:
//   clk_user, reset_n  single clock, asynchronous active-low reset
//   bus                stream bundle (slave modport), see leaf_stream_bridge_if
//   cfg_runs           number of kernel invocations, 0 = unlimited
//   ap_start           kernel start (ap_ctrl_hs)
//   ap_ready, ap_done  kernel handshake returns
//   runs_done          completed invocations, saturating
//   halted             run budget exhausted
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module leaf_stream_bridge #(
    parameter int PAYLOAD_BITS    = 32,
    parameter int NUM_IN_PORTS    = 2,
    parameter int NUM_OUT_PORTS   = 2,
    parameter int FIFO_DEPTH_BITS = 2,
    parameter int RUN_CNT_BITS    = 16
) (
    input  logic                    clk_user,
    input  logic                    reset_n,
    leaf_stream_bridge_if.slave     bus,
    input  logic [RUN_CNT_BITS-1:0] cfg_runs,
    output logic                    ap_start,
    input  logic                    ap_ready,
    input  logic                    ap_done,
    output logic [RUN_CNT_BITS-1:0] runs_done,
    output logic                    halted
);
    localparam int NCH      = NUM_IN_PORTS + NUM_OUT_PORTS;
    localparam int DEPTH    = 1 << FIFO_DEPTH_BITS;
    localparam int PTR_BITS = (FIFO_DEPTH_BITS > 0) ? FIFO_DEPTH_BITS : 1;
    localparam int CNT_BITS = FIFO_DEPTH_BITS + 1;

    //--------------------------------------------------------------------------
    // Channel FIFOs. Input channels occupy indices [0, NUM_IN_PORTS), output
    // channels follow, so one generate loop serves both directions.
    //--------------------------------------------------------------------------
    logic [NCH*PAYLOAD_BITS-1:0] w_wr_data;
    logic [NCH*PAYLOAD_BITS-1:0] w_rd_data;
    logic [NCH-1:0]              w_wr_vld;
    logic [NCH-1:0]              w_rd_ack;
    logic [NCH-1:0]              w_full;
    logic [NCH-1:0]              w_rd_vld;

    assign w_wr_data = {bus.din_kern2bridge, bus.din_if2bridge};
    assign w_wr_vld  = {bus.vld_kern2bridge, bus.vld_if2bridge};
    assign w_rd_ack  = {bus.ack_if2bridge,   bus.ack_kern2bridge};

    assign bus.ack_bridge2if    = ~w_full[NUM_IN_PORTS-1:0];
    assign bus.ack_bridge2kern  = ~w_full[NCH-1:NUM_IN_PORTS];
    assign bus.vld_bridge2kern  = w_rd_vld[NUM_IN_PORTS-1:0];
    assign bus.vld_bridge2if    = w_rd_vld[NCH-1:NUM_IN_PORTS];
    assign bus.dout_bridge2kern = w_rd_data[NUM_IN_PORTS*PAYLOAD_BITS-1:0];
    assign bus.dout_bridge2if   = w_rd_data[NCH*PAYLOAD_BITS-1:NUM_IN_PORTS*PAYLOAD_BITS];

    // Pointers wrap at DEPTH-1 explicitly so a depth of 1 also works.
    function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
        return (p == PTR_BITS'(DEPTH - 1)) ? '0 : p + PTR_BITS'(1);
    endfunction

    for (genvar g = 0; g < NCH; g++) begin : g_fifo
        logic [PAYLOAD_BITS-1:0] r_mem [DEPTH];
        logic [PTR_BITS-1:0]     r_wptr;
        logic [PTR_BITS-1:0]     r_rptr;
        logic [CNT_BITS-1:0]     r_count;
        logic                    w_wr;
        logic                    w_rd;
        logic                    w_empty;

        // ack depends only on stored occupancy, never on this cycle's vld.
        assign w_full[g]   = (r_count == CNT_BITS'(DEPTH));
        assign w_empty     = (r_count == '0);
        assign w_wr        = w_wr_vld[g] & ~w_full[g];
        assign w_rd        = w_rd_ack[g] & ~w_empty;
        assign w_rd_vld[g] = ~w_empty;
        // Masking with empty keeps the data output at zero after reset even
        // though the storage itself is never cleared.
        assign w_rd_data[g*PAYLOAD_BITS +: PAYLOAD_BITS] = w_empty ? '0 : r_mem[r_rptr];

        always_ff @(posedge clk_user or negedge reset_n) begin
            if (!reset_n) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_wr) r_wptr <= ptr_inc(r_wptr);
                if (w_rd) r_rptr <= ptr_inc(r_rptr);
                case ({w_wr, w_rd})
                    2'b10:   r_count <= r_count + CNT_BITS'(1);
                    2'b01:   r_count <= r_count - CNT_BITS'(1);
                    default: ;
                endcase
            end
        end

        // NOTE: storage is deliberately left out of reset; occupancy alone
        // defines which entries are meaningful.
        always_ff @(posedge clk_user) begin
            if (w_wr) r_mem[r_wptr] <= w_wr_data[g*PAYLOAD_BITS +: PAYLOAD_BITS];
        end
    end

    //--------------------------------------------------------------------------
    // Kernel run controller
    //--------------------------------------------------------------------------
    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_HALT} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [RUN_CNT_BITS-1:0] r_runs_done;
    logic [RUN_CNT_BITS-1:0] w_runs_inc;
    logic                    w_done_evt;
    logic                    w_more;

    // A done that coincides with ready in START completes that run at once.
    assign w_done_evt = ap_done & ((r_state == S_RUN) | ((r_state == S_START) & ap_ready));
    assign w_runs_inc = (&r_runs_done) ? r_runs_done : r_runs_done + RUN_CNT_BITS'(1);
    // cfg_runs is compared live at each done, so lowering it takes effect then.
    assign w_more     = (cfg_runs == '0) | (w_runs_inc < cfg_runs);

    always_ff @(posedge clk_user or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_runs_done <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_done_evt) r_runs_done <= w_runs_inc;
        end
    end

    // NOTE: each combinational block assigns its defaults first so no path
    // leaves an output unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_START;
            S_START: begin
                if (w_done_evt)    w_state_nxt = w_more ? S_START : S_HALT;
                else if (ap_ready) w_state_nxt = S_RUN;
            end
            S_RUN:   if (w_done_evt) w_state_nxt = w_more ? S_START : S_HALT;
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ap_start = 1'b0;
        halted   = 1'b0;
        case (r_state)
            S_START: ap_start = 1'b1;
            S_HALT:  halted   = 1'b1;
            default: ;
        endcase
    end

    assign runs_done = r_runs_done;
endmodule

// File: tb/tb_leaf_stream_bridge.sv
`timescale 1ns/1ps
module tb_leaf_stream_bridge;
    localparam int PB    = 32;
    localparam int NIN   = 2;
    localparam int NOUT  = 2;
    localparam int FDB   = 2;
    localparam int RCB   = 16;
    localparam int NCH   = NIN + NOUT;
    localparam int DEPTH = 4;

    logic clk_user = 1'b0;
    logic reset_n  = 1'b0;
    always #5 clk_user = ~clk_user;

    // Main instance
    leaf_stream_bridge_if #(.PAYLOAD_BITS(PB), .NUM_IN_PORTS(NIN), .NUM_OUT_PORTS(NOUT)) u_bus ();
    logic [RCB-1:0] cfg_runs;
    logic [RCB-1:0] runs_done;
    logic           ap_start;
    logic           ap_ready;
    logic           ap_done;
    logic           halted;

    leaf_stream_bridge #(
        .PAYLOAD_BITS(PB), .NUM_IN_PORTS(NIN), .NUM_OUT_PORTS(NOUT),
        .FIFO_DEPTH_BITS(FDB), .RUN_CNT_BITS(RCB)
    ) u_dut (
        .clk_user  (clk_user),
        .reset_n   (reset_n),
        .bus       (u_bus),
        .cfg_runs  (cfg_runs),
        .ap_start  (ap_start),
        .ap_ready  (ap_ready),
        .ap_done   (ap_done),
        .runs_done (runs_done),
        .halted    (halted)
    );

    // Narrow run counter instance so saturation is reachable quickly
    leaf_stream_bridge_if #(.PAYLOAD_BITS(8), .NUM_IN_PORTS(1), .NUM_OUT_PORTS(1)) u_bus_s ();
    logic [2:0] cfg_runs_s;
    logic [2:0] runs_done_s;
    logic       ap_start_s;
    logic       ap_ready_s;
    logic       ap_done_s;
    logic       halted_s;

    leaf_stream_bridge #(
        .PAYLOAD_BITS(8), .NUM_IN_PORTS(1), .NUM_OUT_PORTS(1),
        .FIFO_DEPTH_BITS(1), .RUN_CNT_BITS(3)
    ) u_dut_s (
        .clk_user  (clk_user),
        .reset_n   (reset_n),
        .bus       (u_bus_s),
        .cfg_runs  (cfg_runs_s),
        .ap_start  (ap_start_s),
        .ap_ready  (ap_ready_s),
        .ap_done   (ap_done_s),
        .runs_done (runs_done_s),
        .halted    (halted_s)
    );

    // Channel view: 0..NIN-1 interface->kernel, NIN..NCH-1 kernel->interface
    logic [NCH-1:0]    a_vld;
    logic [NCH-1:0]    a_ack;
    logic [NCH*PB-1:0] a_data;
    assign a_vld  = {u_bus.vld_bridge2if,   u_bus.vld_bridge2kern};
    assign a_ack  = {u_bus.ack_bridge2kern, u_bus.ack_bridge2if};
    assign a_data = {u_bus.dout_bridge2if,  u_bus.dout_bridge2kern};

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: one ideal queue per channel, bounded at DEPTH
    logic [PB-1:0] mq [NCH][$];
    logic [NCH-1:0] d_vld;
    logic [NCH-1:0] d_ack;
    logic [PB-1:0]  d_data [NCH];

    task automatic drive_pins();
        logic [NCH*PB-1:0] flat;
        flat = '0;
        for (int ch = 0; ch < NCH; ch++) flat |= (NCH*PB)'(d_data[ch]) << (ch*PB);
        u_bus.vld_if2bridge   = d_vld[NIN-1:0];
        u_bus.vld_kern2bridge = d_vld[NCH-1:NIN];
        u_bus.ack_kern2bridge = d_ack[NIN-1:0];
        u_bus.ack_if2bridge   = d_ack[NCH-1:NIN];
        u_bus.din_if2bridge   = flat[NIN*PB-1:0];
        u_bus.din_kern2bridge = flat[NCH*PB-1:NIN*PB];
    endtask

    // One clock: compare outputs with the model, apply inputs, advance model.
    task automatic cycle();
        logic [NCH-1:0] wr;
        logic [NCH-1:0] rd;
        @(negedge clk_user);
        for (int ch = 0; ch < NCH; ch++) begin
            int n;
            n = mq[ch].size();
            check($sformatf("vld[%0d]", ch), 64'(1'(a_vld >> ch)), 64'(n > 0));
            check($sformatf("ack[%0d]", ch), 64'(1'(a_ack >> ch)), 64'(n < DEPTH));
            check($sformatf("data[%0d]", ch), 64'(PB'(a_data >> (ch*PB))),
                  (n > 0) ? 64'(mq[ch][0]) : 64'(0));
        end
        drive_pins();
        for (int ch = 0; ch < NCH; ch++) begin
            wr[ch] = d_vld[ch] && (mq[ch].size() < DEPTH);
            rd[ch] = d_ack[ch] && (mq[ch].size() > 0);
        end
        @(posedge clk_user);
        for (int ch = 0; ch < NCH; ch++) begin
            if (rd[ch]) void'(mq[ch].pop_front());
            if (wr[ch]) mq[ch].push_back(d_data[ch]);
        end
    endtask

    // Kernel model: ready one cycle after it sees start, done five cycles later.
    int ks = 0;
    int kc = 0;
    int starts = 0;
    logic prev_start = 1'b0;

    task automatic run_kernel(input int n_dones, input int budget);
        int issued;
        issued = 0;
        for (int c = 0; c < budget && issued < n_dones; c++) begin
            @(negedge clk_user);
            if (ap_start && !prev_start) starts++;
            prev_start = ap_start;
            ap_ready = 1'b0;
            ap_done  = 1'b0;
            case (ks)
                0: if (ap_start) ks = 1;
                1: begin ap_ready = 1'b1; ks = 2; kc = 0; end
                default: begin
                    kc++;
                    if (kc == 5) begin ap_done = 1'b1; ks = 0; issued++; end
                end
            endcase
        end
        @(posedge clk_user);
        #1;
        ap_ready = 1'b0;
        ap_done  = 1'b0;
        check("kernel_dones_issued", 64'(issued), 64'(n_dones));
    endtask

    task automatic clear_model();
        for (int ch = 0; ch < NCH; ch++) mq[ch].delete();
    endtask

    localparam logic [PB-1:0] W0 = 32'h1000_0000;

    initial begin
        int highs;
        d_vld = '0;
        d_ack = '0;
        for (int ch = 0; ch < NCH; ch++) d_data[ch] = '0;
        drive_pins();
        cfg_runs = 16'd3;
        ap_ready = 1'b0;
        ap_done  = 1'b0;
        u_bus_s.din_if2bridge   = '0;
        u_bus_s.vld_if2bridge   = '0;
        u_bus_s.ack_kern2bridge = '0;
        u_bus_s.din_kern2bridge = '0;
        u_bus_s.vld_kern2bridge = '0;
        u_bus_s.ack_if2bridge   = '0;
        cfg_runs_s = 3'd0;
        ap_ready_s = 1'b0;
        ap_done_s  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk_user);
        #1;
        check("rst_ack_if",    64'(u_bus.ack_bridge2if),    64'h3);
        check("rst_ack_kern",  64'(u_bus.ack_bridge2kern),  64'h3);
        check("rst_vld_kern",  64'(u_bus.vld_bridge2kern),  64'h0);
        check("rst_vld_if",    64'(u_bus.vld_bridge2if),    64'h0);
        check("rst_dout_kern", 64'(u_bus.dout_bridge2kern), 64'h0);
        check("rst_dout_if",   64'(u_bus.dout_bridge2if),   64'h0);
        check("rst_ap_start",  64'(ap_start),  64'h0);
        check("rst_runs_done", 64'(runs_done), 64'h0);
        check("rst_halted",    64'(halted),    64'h0);
        @(negedge clk_user);
        reset_n = 1'b1;

        // Single word on input channel 1
        d_vld[1] = 1'b1;
        d_data[1] = 32'hDEAD_BEEF;
        cycle();
        d_vld[1] = 1'b0;
        #1;
        check("single_vld1", 64'(u_bus.vld_bridge2kern[1]), 64'h1);
        check("single_data1", 64'(u_bus.dout_bridge2kern[2*PB-1:PB]), 64'hDEAD_BEEF);
        check("single_vld0", 64'(u_bus.vld_bridge2kern[0]), 64'h0);
        d_ack[1] = 1'b1;
        cycle();
        d_ack[1] = 1'b0;

        // Fill channel 0 with the consumer stalled
        d_vld[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d_data[0] = W0 + PB'(k);
            cycle();
            #1;
            check($sformatf("fill_ack_%0d", k), 64'(u_bus.ack_bridge2if[0]), 64'(k < 3));
        end
        d_data[0] = W0 + 32'd4;
        cycle();
        #1;
        check("full_refuse_ack", 64'(u_bus.ack_bridge2if[0]), 64'h0);
        // Read while full with producer still valid: no write this cycle
        d_ack[0] = 1'b1;
        cycle();
        #1;
        check("rd_at_full_ack", 64'(u_bus.ack_bridge2if[0]), 64'h1);
        check("rd_at_full_head", 64'(u_bus.dout_bridge2kern[PB-1:0]), 64'(W0 + 32'd1));
        d_ack[0] = 1'b0;
        cycle();
        #1;
        check("refill_ack", 64'(u_bus.ack_bridge2if[0]), 64'h0);
        d_vld[0] = 1'b0;
        d_ack[0] = 1'b1;
        repeat (4) cycle();
        #1;
        check("drain_vld0", 64'(u_bus.vld_bridge2kern[0]), 64'h0);

        // Randomised traffic on all channels, both directions
        for (int c = 0; c < 300; c++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                d_vld[ch]  = ($urandom_range(0, 3) != 0);
                d_ack[ch]  = ($urandom_range(0, 1) != 0);
                d_data[ch] = $urandom;
            end
            cycle();
        end
        d_vld = '0;
        d_ack = '1;
        repeat (DEPTH + 1) cycle();
        #1;
        check("rand_drained", 64'(a_vld), 64'h0);

        // Asynchronous reset with three words buffered
        d_ack = '0;
        d_vld = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            d_data[0] = 32'hA0 + PB'(k);
            cycle();
        end
        d_vld = '0;
        #1;
        check("pre_reset_vld0", 64'(u_bus.vld_bridge2kern[0]), 64'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_vld_drop",  64'(u_bus.vld_bridge2kern),  64'h0);
        check("async_data_zero", 64'(u_bus.dout_bridge2kern), 64'h0);
        check("async_ap_start",  64'(ap_start), 64'h0);
        clear_model();
        drive_pins();
        cfg_runs = 16'd3;
        repeat (2) @(negedge clk_user);
        reset_n = 1'b1;
        #1;
        check("rel_ack_if",   64'(u_bus.ack_bridge2if),  64'h3);
        check("rel_vld_kern", 64'(u_bus.vld_bridge2kern), 64'h0);
        check("rel_ap_start", 64'(ap_start), 64'h0);
        @(posedge clk_user);
        #1;
        check("start_after_reset", 64'(ap_start), 64'h1);

        // Run budget of three
        ks = 0; starts = 0; prev_start = 1'b0;
        run_kernel(3, 200);
        check("budget_starts",    64'(starts),    64'd3);
        check("budget_runs_done", 64'(runs_done), 64'd3);
        check("budget_halted",    64'(halted),    64'h1);
        check("budget_ap_start",  64'(ap_start),  64'h0);
        highs = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_user);
            if (ap_start) highs++;
            ap_done = (c == 5);
        end
        ap_done = 1'b0;
        @(posedge clk_user);
        #1;
        check("halt_no_start",     64'(highs),     64'd0);
        check("halt_done_ignored", 64'(runs_done), 64'd3);
        check("halt_sticky",       64'(halted),    64'h1);

        // Continuous mode, then lower the budget below the count
        reset_n = 1'b0;
        cfg_runs = 16'd0;
        repeat (2) @(negedge clk_user);
        reset_n = 1'b1;
        ks = 0; starts = 0; prev_start = 1'b0;
        run_kernel(20, 400);
        check("cont_runs_done", 64'(runs_done), 64'd20);
        check("cont_starts",    64'(starts),    64'd20);
        check("cont_ap_start",  64'(ap_start),  64'h1);
        check("cont_halted",    64'(halted),    64'h0);
        cfg_runs = 16'd5;
        run_kernel(1, 50);
        check("lowered_starts",    64'(starts),    64'd21);
        check("lowered_runs_done", 64'(runs_done), 64'd21);
        check("lowered_halted",    64'(halted),    64'h1);
        check("lowered_ap_start",  64'(ap_start),  64'h0);

        // Saturation of a 3-bit run counter: ready and done every cycle
        check("sat_pre", 64'(runs_done_s), 64'd0);
        @(negedge clk_user);
        ap_ready_s = 1'b1;
        ap_done_s  = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk_user);
            #1;
            check($sformatf("sat_runs_%0d", k), 64'(runs_done_s), 64'((k < 7) ? k : 7));
        end
        check("sat_ap_start", 64'(ap_start_s), 64'h1);
        check("sat_halted",   64'(halted_s),   64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
